// File: rtl/freelist_ckpt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freelist_ckpt_ctrl_pkg
// Brief    : Shared sizes, checkpoint entry type and free-list modular add.
// Revision : 1.0 - initial release
// ============================================================================
package freelist_ckpt_ctrl_pkg;

   localparam int NUM_CP  = 8;
   localparam int CP_LOG  = 3;
   localparam int FL_SIZE = 96;
   localparam int FL_LOG  = 7;
   localparam int WIDTH   = 4;
   localparam int CNT_W   = $clog2(WIDTH + 1);

   typedef struct packed {
      logic              valid;
      logic [FL_LOG-1:0] head;
   } ckpt_entry_t;

   // The offset never exceeds WIDTH, so one conditional subtract wraps it.
   function automatic logic [FL_LOG-1:0] fl_add(input logic [FL_LOG-1:0] a,
                                                input logic [CNT_W-1:0]  b);
      logic [FL_LOG:0] sum;
      sum = {1'b0, a} + (FL_LOG+1)'(b);
      if (sum >= (FL_LOG+1)'(FL_SIZE))
         sum = sum - (FL_LOG+1)'(FL_SIZE);
      return sum[FL_LOG-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/freelist_ckpt_ctrl_lane_offset.sv
`default_nettype none
// ============================================================================
// Module   : ckpt_lane_offset
// Brief    : Per-lane prefix counts of branches (exclusive) and free-register
//            requests (inclusive) for tag and head offset generation.
// Revision : 1.0 - initial release
// ============================================================================
module ckpt_lane_offset
   import freelist_ckpt_ctrl_pkg::*;
(
   input  logic [WIDTH-1:0]             i_branch_valid,
   input  logic [WIDTH-1:0]             i_req_free,
   output logic [WIDTH-1:0][CP_LOG-1:0] o_br_ofs,
   output logic [WIDTH-1:0][CNT_W-1:0]  o_req_cnt,
   output logic [CNT_W-1:0]             o_br_total
);

   logic [CNT_W-1:0] w_br_acc;
   logic [CNT_W-1:0] w_req_acc;

   always_comb begin
      w_br_acc  = '0;
      w_req_acc = '0;
      o_br_ofs  = '0;
      o_req_cnt = '0;
      for (int k = 0; k < WIDTH; k++) begin
         o_br_ofs[k]  = CP_LOG'(w_br_acc);
         w_req_acc    = w_req_acc + CNT_W'(i_req_free[k]);
         o_req_cnt[k] = w_req_acc;
         w_br_acc     = w_br_acc + CNT_W'(i_branch_valid[k]);
      end
      o_br_total = w_br_acc;
   end

endmodule
`default_nettype wire

// File: rtl/freelist_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : freelist_ckpt_ctrl
// Brief    : Branch checkpoint controller for the speculative free-list head.
//            Optional statistics counters: FREELIST_CKPT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module freelist_ckpt_ctrl
   import freelist_ckpt_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall_i,
   input  logic                     recoverFlag_i,
   input  logic [FL_LOG-1:0]        freeListHead_i,
   input  logic [WIDTH-1:0]         reqFreeReg_i,
   input  logic [WIDTH-1:0]         branchValid_i,
   input  logic                     resolveValid_i,
   input  logic [CP_LOG-1:0]        resolveTag_i,
   input  logic                     mispredict_i,
   output logic [WIDTH*CP_LOG-1:0]  cpTag_o,
   output logic                     cpFull_o,
   output logic                     ctrlVerified_o,
   output logic                     flagRecoverEX_o,
   output logic [FL_LOG-1:0]        freeListHeadCp_o
`ifdef FREELIST_CKPT_STATS_EN
   ,
   output logic [15:0]              statMispredict_o,
   output logic [15:0]              statFullStall_o
`endif
);

   ckpt_entry_t       r_cp [NUM_CP];
   logic [CP_LOG-1:0] r_oldest;
   logic [CP_LOG-1:0] r_next;
   logic [CP_LOG:0]   r_count;
   logic              r_verified;
   logic [FL_LOG-1:0] r_head_cp;

   logic [WIDTH-1:0][CP_LOG-1:0] w_br_ofs;
   logic [WIDTH-1:0][CNT_W-1:0]  w_req_cnt;
   logic [CNT_W-1:0]             w_br_total;
   logic [WIDTH-1:0][CP_LOG-1:0] w_lane_tag;
   logic [WIDTH-1:0][FL_LOG-1:0] w_lane_head;

   logic              w_res_hit;
   logic              w_mispredict;
   logic              w_release;
   logic              w_alloc;
   logic              w_oldest_busy;
   logic              w_drain;
   logic [CP_LOG:0]   w_free;
   logic [CP_LOG:0]   w_alloc_n;
   logic [CP_LOG:0]   w_drain_n;
   logic [CP_LOG-1:0] w_tag_dist;

   ckpt_lane_offset u_lane_offset (
      .i_branch_valid (branchValid_i),
      .i_req_free     (reqFreeReg_i),
      .o_br_ofs       (w_br_ofs),
      .o_req_cnt      (w_req_cnt),
      .o_br_total     (w_br_total)
   );

   generate
      for (genvar k = 0; k < WIDTH; k++) begin : g_lane
         assign w_lane_tag[k]                 = r_next + w_br_ofs[k];
         assign w_lane_head[k]                = fl_add(freeListHead_i, w_req_cnt[k]);
         assign cpTag_o[k*CP_LOG +: CP_LOG]   = w_lane_tag[k];
      end
   endgenerate

   assign w_free   = (CP_LOG+1)'(NUM_CP) - r_count;
   assign cpFull_o = w_free < (CP_LOG+1)'(WIDTH);

   assign w_res_hit    = resolveValid_i && r_cp[resolveTag_i].valid;
   assign w_mispredict = w_res_hit &&  mispredict_i && !recoverFlag_i;
   assign w_release    = w_res_hit && !mispredict_i && !recoverFlag_i;
   assign w_alloc      = !stall_i && !cpFull_o && !w_mispredict && !recoverFlag_i;
   assign w_alloc_n    = w_alloc ? (CP_LOG+1)'(w_br_total) : '0;

   // A release of the oldest slot lets it drain in the same cycle.
   assign w_oldest_busy = r_cp[r_oldest].valid && !(w_release && (resolveTag_i == r_oldest));
   assign w_drain       = (r_count != '0) && !w_oldest_busy;
   assign w_drain_n     = (CP_LOG+1)'(w_drain);
   assign w_tag_dist    = resolveTag_i - r_oldest;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CP; i++)
            r_cp[i] <= '0;
         r_oldest   <= '0;
         r_next     <= '0;
         r_count    <= '0;
         r_verified <= 1'b0;
         r_head_cp  <= '0;
      end else begin
         r_verified <= w_mispredict;
         if (w_mispredict)
            r_head_cp <= r_cp[resolveTag_i].head;

         if (recoverFlag_i) begin
            for (int i = 0; i < NUM_CP; i++)
               r_cp[i].valid <= 1'b0;
            r_oldest <= '0;
            r_next   <= '0;
            r_count  <= '0;
         end else begin
            if (w_release)
               r_cp[resolveTag_i].valid <= 1'b0;

            if (w_mispredict) begin
               // The resolved slot stays counted but invalid so it drains in order.
               for (int i = 0; i < NUM_CP; i++)
                  if ((CP_LOG'(i) - r_oldest) >= w_tag_dist)
                     r_cp[i].valid <= 1'b0;
               r_next  <= resolveTag_i + CP_LOG'(1);
               r_count <= {1'b0, w_tag_dist} + (CP_LOG+1)'(1) - w_drain_n;
            end else begin
               for (int k = 0; k < WIDTH; k++)
                  if (w_alloc && branchValid_i[k])
                     r_cp[w_lane_tag[k]] <= '{valid: 1'b1, head: w_lane_head[k]};
               r_next  <= r_next + CP_LOG'(w_alloc_n);
               r_count <= r_count + w_alloc_n - w_drain_n;
            end

            if (w_drain)
               r_oldest <= r_oldest + CP_LOG'(1);
         end
      end
   end

   assign ctrlVerified_o   = r_verified;
   assign flagRecoverEX_o  = r_verified;
   assign freeListHeadCp_o = r_head_cp;

`ifdef FREELIST_CKPT_STATS_EN
   logic [15:0] r_stat_mp;
   logic [15:0] r_stat_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_mp   <= '0;
         r_stat_full <= '0;
      end else begin
         if (w_mispredict && (r_stat_mp != 16'hFFFF))
            r_stat_mp <= r_stat_mp + 16'd1;
         if (cpFull_o && (|branchValid_i) && (r_stat_full != 16'hFFFF))
            r_stat_full <= r_stat_full + 16'd1;
      end
   end

   assign statMispredict_o = r_stat_mp;
   assign statFullStall_o  = r_stat_full;
`endif

endmodule
`default_nettype wire
